modular_double_iter: RTL and testbench



---
 rtl/modular_double_iter.sv | 77 +++++++
 tb/tb_modular_double_iter.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/modular_double_iter.sv
// Sequential modular scaler: y = x * 2^k mod M, one conditional-subtract doubling per clock.
// Single operand in flight; valid/ready on both sides.
module modular_double_iter #(
  parameter int data_width  = 12,
  parameter int M           = 3329,
  parameter int shift_width = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [data_width-1:0]  in_data,
  input  logic [shift_width-1:0] in_shift,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [data_width-1:0]  out_data,
  output logic                   busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam logic [data_width-1:0] M_D   = M[data_width-1:0];
  localparam logic [data_width:0]   M_EXT = M[data_width:0];

  logic [1:0]             r_state;
  logic [data_width-1:0]  r_acc;
  logic [shift_width-1:0] r_cnt;

  logic [data_width:0]    w_t;
  logic [data_width-1:0]  w_shl;
  logic [data_width-1:0]  w_dbl;
  logic [data_width-1:0]  w_red;
  logic                   w_accept;

  // Subtraction is done at data_width bits: when t >= M the true
  // difference is < M, so the dropped carry bit is always zero.
  assign w_t   = {r_acc, 1'b0};
  assign w_shl = {r_acc[data_width-2:0], 1'b0};
  assign w_dbl = (w_t >= M_EXT) ? (w_shl - M_D) : w_shl;
  assign w_red = (in_data >= M_D) ? (in_data - M_D) : in_data;

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == HOLD);
  assign busy      = (r_state == RUN) || (r_state == HOLD);
  assign out_data  = r_acc;
  assign w_accept  = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_acc   <= w_red;
            r_cnt   <= in_shift;
            r_state <= (in_shift == '0) ? HOLD : RUN;
          end
        end
        RUN: begin
          r_acc <= w_dbl;
          r_cnt <= r_cnt - shift_width'(1);
          if (r_cnt == shift_width'(1)) r_state <= HOLD;
        end
        HOLD: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_modular_double_iter.sv
// Directed bench for modular_double_iter (M=3329, 12-bit data, 4-bit shift).
module tb_modular_double_iter;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_data;
  logic [3:0]  in_shift;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_data;
  logic        busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  modular_double_iter #(.data_width(12), .M(3329), .shift_width(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_shift(in_shift),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present an operand at a negedge and return #1 after the capture edge;
  // the inputs are then scrambled to show they are not re-sampled.
  task automatic start(input logic [11:0] x, input logic [3:0] k);
    @(negedge clk);
    in_valid = 1'b1; in_data = x; in_shift = k;
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_data = ~x; in_shift = ~k;
  endtask

  // Counts cycles after the capture edge until out_valid; -1 if it never comes.
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (out_valid) begin lat = n; break; end
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (out_data !== 12'd0) $display("FAIL reset_out_data got %0d want 0", out_data); else pass_cnt++;
  endtask

  task automatic test_basic();
    int lat;
    start(12'd1665, 4'd1);
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL basic_in_ready_run got %b want 0", in_ready); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1) $display("FAIL basic_busy_run got %b want 1", busy); else pass_cnt++;
    wait_valid(lat);
    total_cnt++; if (lat !== 2) $display("FAIL basic_latency got %0d want 2", lat); else pass_cnt++;
    total_cnt++; if (out_data !== 12'd1) $display("FAIL basic_data got %0d want 1", out_data); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL basic_in_ready_hold got %b want 0", in_ready); else pass_cnt++;
    handshake();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL basic_valid_drop got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL basic_in_ready_idle got %b want 1", in_ready); else pass_cnt++;
  endtask

  task automatic test_vectors();
    logic [11:0] xs [7] = '{12'd3328, 12'd5, 12'd1,   12'd1,    12'd3329, 12'd3000, 12'd4095};
    logic [3:0]  ks [7] = '{4'd1,     4'd3,  4'd12,   4'd15,    4'd0,     4'd0,     4'd0};
    logic [11:0] ys [7] = '{12'd3327, 12'd40, 12'd767, 12'd2807, 12'd0,   12'd3000, 12'd766};
    int lat;
    for (int i = 0; i < 7; i++) begin
      start(xs[i], ks[i]);
      wait_valid(lat);
      total_cnt++;
      if (lat !== int'(ks[i]) + 1) $display("FAIL vec%0d_latency got %0d want %0d", i, lat, int'(ks[i]) + 1);
      else pass_cnt++;
      total_cnt++;
      if (out_data !== ys[i]) $display("FAIL vec%0d_data x=%0d k=%0d got %0d want %0d", i, xs[i], ks[i], out_data, ys[i]);
      else pass_cnt++;
      handshake();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    start(12'd7, 4'd2);
    wait_valid(lat);
    total_cnt++; if (lat !== 3) $display("FAIL bp_latency got %0d want 3", lat); else pass_cnt++;
    in_valid = 1'b1; in_data = 12'd9; in_shift = 4'd1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total_cnt++;
      if (out_valid !== 1'b1 || out_data !== 12'd28 || in_ready !== 1'b0)
        $display("FAIL bp_hold_c%0d got valid=%b data=%0d in_ready=%b want 1/28/0", c, out_valid, out_data, in_ready);
      else pass_cnt++;
    end
    // Handshake edge with in_valid still high: must not capture here.
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    total_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL bp_no_same_cycle_accept got valid=%b in_ready=%b want 0/1", out_valid, in_ready); else pass_cnt++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    total_cnt++; if (in_ready !== 1'b0 || busy !== 1'b1)
      $display("FAIL bp_next_capture got in_ready=%b busy=%b want 0/1", in_ready, busy); else pass_cnt++;
    wait_valid(lat);
    total_cnt++; if (lat !== 2 || out_data !== 12'd18)
      $display("FAIL bp_second_op got lat=%0d data=%0d want 2/18", lat, out_data); else pass_cnt++;
    handshake();
  endtask

  task automatic test_reset_mid_run();
    int lat;
    start(12'd1, 4'd10);
    repeat (3) @(negedge clk);
    total_cnt++; if (busy !== 1'b1) $display("FAIL midrst_busy_before got %b want 1", busy); else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 12'd0)
      $display("FAIL midrst_async got in_ready=%b valid=%b busy=%b data=%0d want 1/0/0/0",
               in_ready, out_valid, busy, out_data);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    start(12'd2, 4'd1);
    wait_valid(lat);
    total_cnt++; if (lat !== 2 || out_data !== 12'd4)
      $display("FAIL midrst_after got lat=%0d data=%0d want 2/4", lat, out_data); else pass_cnt++;
    handshake();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_shift = '0; out_ready = 1'b0;
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_basic();
    test_vectors();
    test_backpressure();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
